// File: rtl/logits_argmax_if.sv
// Handshake bundle for logits_argmax: one logits frame in, one
// classification result out, each on its own valid/ready pair.
interface logits_argmax_if #(
    parameter int OUTPUT_SIZE       = 3,
    parameter int OUTPUT_DATA_WIDTH = 16
);
    localparam int IDX_WIDTH = (OUTPUT_SIZE > 2) ? $clog2(OUTPUT_SIZE) : 1;

    logic                                     i_valid;
    logic                                     i_ready;
    logic [OUTPUT_SIZE*OUTPUT_DATA_WIDTH-1:0] i_logits;
    logic                                     o_valid;
    logic                                     o_ready;
    logic [IDX_WIDTH-1:0]                     o_class;
    logic [OUTPUT_DATA_WIDTH-1:0]             o_max_logit;
    logic [OUTPUT_DATA_WIDTH:0]               o_margin;

    // Producer of frames / consumer of results.
    modport master (
        output i_valid, i_logits, o_ready,
        input  i_ready, o_valid, o_class, o_max_logit, o_margin
    );

    // The argmax block itself.
    modport slave (
        input  i_valid, i_logits, o_ready,
        output i_ready, o_valid, o_class, o_max_logit, o_margin
    );
endinterface

// File: rtl/logits_argmax.sv
// Serial argmax over one logits frame: captures the frame, scans one logit
// per cycle tracking top-1 / top-2, then presents class, max and margin.
module logits_argmax #(
    parameter int OUTPUT_SIZE       = 3,
    parameter int OUTPUT_DATA_WIDTH = 16
) (
    input  logic           clk,
    input  logic           rst,
    logits_argmax_if.slave bus
);
    localparam int W         = OUTPUT_DATA_WIDTH;
    localparam int IDX_WIDTH = (OUTPUT_SIZE > 2) ? $clog2(OUTPUT_SIZE) : 1;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(OUTPUT_SIZE - 1);
    localparam logic signed [W-1:0]  MOST_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t state_q, state_d;

    logic [OUTPUT_SIZE-1:0][W-1:0] frame;
    logic signed [W-1:0]           best, second;
    logic [IDX_WIDTH-1:0]          best_idx, cnt;

    logic [IDX_WIDTH-1:0]          class_q;
    logic [W-1:0]                  max_q;
    logic [W:0]                    margin_q;

    logic signed [W-1:0]           x, nxt_best, nxt_second;
    logic [IDX_WIDTH-1:0]          nxt_idx;
    logic [W:0]                    nxt_margin;

    logic accept, last;

    assign accept = (state_q == IDLE) && bus.i_valid;
    assign last   = (cnt == LAST_IDX);

    // Outputs are either registers or a decode of the state register.
    assign bus.i_ready     = (state_q == IDLE);
    assign bus.o_valid     = (state_q == DONE);
    assign bus.o_class     = class_q;
    assign bus.o_max_logit = max_q;
    assign bus.o_margin    = margin_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.i_valid) state_d = SCAN;
            SCAN:    if (last)        state_d = DONE;
            DONE:    if (bus.o_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Top-2 update for the current element; strict '>' keeps the lowest
    // index on ties and pushes an equal-to-best value into second.
    always_comb begin
        x          = frame[cnt];
        nxt_best   = best;
        nxt_second = second;
        nxt_idx    = best_idx;
        if (x > best) begin
            nxt_second = best;
            nxt_best   = x;
            nxt_idx    = cnt;
        end else if (x > second) begin
            nxt_second = x;
        end
        // One extra bit so max - second never wraps (worst case 2^W - 1).
        nxt_margin = {nxt_best[W-1], nxt_best} - {nxt_second[W-1], nxt_second};
    end

    // Frame capture, scan registers and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame    <= '0;
            best     <= '0;
            second   <= '0;
            best_idx <= '0;
            cnt      <= '0;
            class_q  <= '0;
            max_q    <= '0;
            margin_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    frame    <= bus.i_logits;
                    best     <= bus.i_logits[W-1:0];
                    best_idx <= '0;
                    second   <= MOST_NEG;
                    cnt      <= IDX_WIDTH'(1);
                end
                SCAN: begin
                    best     <= nxt_best;
                    second   <= nxt_second;
                    best_idx <= nxt_idx;
                    cnt      <= cnt + 1'b1;
                    if (last) begin
                        class_q  <= nxt_idx;
                        max_q    <= nxt_best;
                        margin_q <= nxt_margin;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_logits_argmax.sv
// Directed self-checking bench for logits_argmax (3 classes, 16-bit logits).
module tb_logits_argmax;
    localparam int N = 3;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logits_argmax_if #(.OUTPUT_SIZE(N), .OUTPUT_DATA_WIDTH(W)) bus ();

    logits_argmax #(.OUTPUT_SIZE(N), .OUTPUT_DATA_WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept a frame (block must be in IDLE), then count edges until o_valid.
    task automatic send_frame(input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] c, output int lat);
        bus.i_logits = {c, b, a};
        bus.i_valid  = 1'b1;
        step();
        bus.i_valid  = 1'b0;
        lat = 0;
        while (bus.o_valid !== 1'b1 && lat < 50) begin
            step();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.i_valid  = 1'b0;
        bus.o_ready  = 1'b0;
        bus.i_logits = '0;
        step();
        step();
        checks++; if (bus.i_ready !== 1'b1) begin errors++; $display("FAIL reset_i_ready got=%b exp=1", bus.i_ready); end
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL reset_o_valid got=%b exp=0", bus.o_valid); end
        checks++; if (bus.o_class !== 2'd0) begin errors++; $display("FAIL reset_o_class got=%0d exp=0", bus.o_class); end
        checks++; if (bus.o_max_logit !== 16'd0) begin errors++; $display("FAIL reset_o_max got=%0d exp=0", bus.o_max_logit); end
        checks++; if (bus.o_margin !== 17'd0) begin errors++; $display("FAIL reset_o_margin got=%0d exp=0", bus.o_margin); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int lat;
        bus.o_ready = 1'b1;
        send_frame(16'd100, -16'sd5, 16'd300, lat);
        checks++; if (lat != 2) begin errors++; $display("FAIL basic_latency got=%0d exp=2", lat); end
        checks++; if (bus.i_ready !== 1'b0) begin errors++; $display("FAIL basic_i_ready_done got=%b exp=0", bus.i_ready); end
        checks++; if (bus.o_class !== 2'd2) begin errors++; $display("FAIL basic_class got=%0d exp=2", bus.o_class); end
        checks++; if (bus.o_max_logit !== 16'd300) begin errors++; $display("FAIL basic_max got=%0d exp=300", $signed(bus.o_max_logit)); end
        checks++; if (bus.o_margin !== 17'd200) begin errors++; $display("FAIL basic_margin got=%0d exp=200", bus.o_margin); end
        step();
        checks++; if (bus.i_ready !== 1'b1) begin errors++; $display("FAIL basic_i_ready_back got=%b exp=1", bus.i_ready); end
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL basic_o_valid_drop got=%b exp=0", bus.o_valid); end
    endtask

    // Ties and extremes from a table of hand-computed results.
    task automatic test_directed();
        logic [W-1:0] va [4] = '{16'd50, 16'd10, 16'h8000, 16'h7FFF};
        logic [W-1:0] vb [4] = '{16'd50, 16'd50, 16'h8000, 16'h8000};
        logic [W-1:0] vc [4] = '{16'd10, 16'd50, 16'h8000, 16'h8000};
        logic [1:0]   ec [4] = '{2'd0, 2'd1, 2'd0, 2'd0};
        logic [W-1:0] em [4] = '{16'd50, 16'd50, 16'h8000, 16'h7FFF};
        logic [W:0]   eg [4] = '{17'd0, 17'd0, 17'd0, 17'd65535};
        int lat;
        bus.o_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_frame(va[i], vb[i], vc[i], lat);
            checks++; if (lat != 2) begin errors++; $display("FAIL vec%0d_latency got=%0d exp=2", i, lat); end
            checks++; if (bus.o_class !== ec[i]) begin errors++; $display("FAIL vec%0d_class got=%0d exp=%0d", i, bus.o_class, ec[i]); end
            checks++; if (bus.o_max_logit !== em[i]) begin errors++; $display("FAIL vec%0d_max got=%0d exp=%0d", i, $signed(bus.o_max_logit), $signed(em[i])); end
            checks++; if (bus.o_margin !== eg[i]) begin errors++; $display("FAIL vec%0d_margin got=%0d exp=%0d", i, bus.o_margin, eg[i]); end
            step();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        bus.o_ready = 1'b0;
        send_frame(16'd7, 16'd9, 16'd3, lat);
        checks++; if (lat != 2) begin errors++; $display("FAIL bp_latency got=%0d exp=2", lat); end
        bus.i_logits = {16'd0, 16'd0, 16'd1000};
        bus.i_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (bus.o_valid !== 1'b1 || bus.i_ready !== 1'b0 || bus.o_class !== 2'd1 ||
                bus.o_max_logit !== 16'd9 || bus.o_margin !== 17'd2) begin
                errors++;
                $display("FAIL bp_hold%0d got v=%b rdy=%b cls=%0d max=%0d mrg=%0d exp v=1 rdy=0 cls=1 max=9 mrg=2",
                         i, bus.o_valid, bus.i_ready, bus.o_class, bus.o_max_logit, bus.o_margin);
            end
        end
        bus.o_ready = 1'b1;
        step();  // output handshake edge: must not also accept
        checks++; if (bus.i_ready !== 1'b1) begin errors++; $display("FAIL bp_no_same_cycle_accept got i_ready=%b exp=1", bus.i_ready); end
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL bp_o_valid_drop got=%b exp=0", bus.o_valid); end
        step();  // next frame accepted here
        bus.i_valid = 1'b0;
        checks++; if (bus.i_ready !== 1'b0) begin errors++; $display("FAIL bp_next_accept got i_ready=%b exp=0", bus.i_ready); end
        lat = 0;
        while (bus.o_valid !== 1'b1 && lat < 50) begin step(); lat++; end
        checks++; if (lat != 2) begin errors++; $display("FAIL bp2_latency got=%0d exp=2", lat); end
        checks++; if (bus.o_class !== 2'd0) begin errors++; $display("FAIL bp2_class got=%0d exp=0", bus.o_class); end
        checks++; if (bus.o_max_logit !== 16'd1000) begin errors++; $display("FAIL bp2_max got=%0d exp=1000", $signed(bus.o_max_logit)); end
        checks++; if (bus.o_margin !== 17'd1000) begin errors++; $display("FAIL bp2_margin got=%0d exp=1000", bus.o_margin); end
        step();
    endtask

    task automatic test_volatility();
        int lat;
        bus.o_ready  = 1'b1;
        bus.i_logits = {16'd8, 16'd20, 16'd5};
        bus.i_valid  = 1'b1;
        step();
        bus.i_valid = 1'b0;
        lat = 0;
        while (bus.o_valid !== 1'b1 && lat < 50) begin
            bus.i_logits = {16'($urandom), 16'($urandom), 16'($urandom)};
            step();
            lat++;
        end
        checks++; if (lat != 2) begin errors++; $display("FAIL vol_latency got=%0d exp=2", lat); end
        checks++; if (bus.o_class !== 2'd1) begin errors++; $display("FAIL vol_class got=%0d exp=1", bus.o_class); end
        checks++; if (bus.o_max_logit !== 16'd20) begin errors++; $display("FAIL vol_max got=%0d exp=20", $signed(bus.o_max_logit)); end
        checks++; if (bus.o_margin !== 17'd12) begin errors++; $display("FAIL vol_margin got=%0d exp=12", bus.o_margin); end
        step();
    endtask

    task automatic test_reset_mid();
        int lat;
        logic seen;
        bus.o_ready  = 1'b1;
        bus.i_logits = {16'd2, 16'd1, 16'd400};
        bus.i_valid  = 1'b1;
        step();
        bus.i_valid = 1'b0;
        step();      // mid-SCAN
        rst = 1'b1;
        #1;          // no clock edge yet: reset acts asynchronously
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL rst_o_valid got=%b exp=0", bus.o_valid); end
        checks++; if (bus.i_ready !== 1'b1) begin errors++; $display("FAIL rst_i_ready got=%b exp=1", bus.i_ready); end
        checks++; if (bus.o_class !== 2'd0) begin errors++; $display("FAIL rst_o_class got=%0d exp=0", bus.o_class); end
        checks++; if (bus.o_max_logit !== 16'd0) begin errors++; $display("FAIL rst_o_max got=%0d exp=0", bus.o_max_logit); end
        checks++; if (bus.o_margin !== 17'd0) begin errors++; $display("FAIL rst_o_margin got=%0d exp=0", bus.o_margin); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus.o_valid === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_no_pulse got=%b exp=0", seen); end
        send_frame(16'd1, 16'd2, 16'd3, lat);
        checks++; if (lat != 2) begin errors++; $display("FAIL post_rst_latency got=%0d exp=2", lat); end
        checks++; if (bus.o_class !== 2'd2) begin errors++; $display("FAIL post_rst_class got=%0d exp=2", bus.o_class); end
        checks++; if (bus.o_max_logit !== 16'd3) begin errors++; $display("FAIL post_rst_max got=%0d exp=3", $signed(bus.o_max_logit)); end
        checks++; if (bus.o_margin !== 17'd1) begin errors++; $display("FAIL post_rst_margin got=%0d exp=1", bus.o_margin); end
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_directed();
        test_backpressure();
        test_volatility();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
